act_stream: RTL
===============

# act_stream

Parametrised, pipelined, multi-mode activation unit for the CNN datapath. Processes R×C signed lanes per beat under a valid/ready stream handshake, applying bypass, ReLU, leaky ReLU or clipped ReLU, then narrowing each lane to the output width with saturation. Sits between the convolution accumulator array and the pooling/next-layer buffers. Mode is sampled once per frame, and a saturation statistic is kept for quantisation tuning.

## Interface
- In_d_W, 18: input lane width, signed two's complement.
- Out_d_W, 16: output lane width, signed; must satisfy 2 ≤ Out_d_W ≤ In_d_W.
- R, 3: rows per beat.
- C, 3: columns per beat; lane count N = R*C.
- LEAK_SH, 3: leaky-ReLU right-shift amount (slope 2^-LEAK_SH); must satisfy 0 ≤ LEAK_SH < In_d_W.
- CLIP, 6<<8: clipped-ReLU ceiling, as a non-negative In_d_W-bit value.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- clr, input, 1: synchronous, active-low reset.
- mode, input, 2: 00 bypass, 01 ReLU, 10 leaky ReLU, 11 clipped ReLU.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: unit can accept a beat.
- in_last, input, 1: final beat of the frame.
- X, input, In_d_W*N: lane k occupies bits [In_d_W*(k+1)-1 : In_d_W*k].
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: downstream accepts.
- out_last, output, 1: in_last delayed with its beat.
- Z, output, Out_d_W*N: lane k occupies bits [Out_d_W*(k+1)-1 : Out_d_W*k].
- sat_cnt, output, 16: count of output beats in which at least one lane saturated.

## Operation
- Frame tracking: the sof flag is 1 after reset and after every accepted beat with in_last=1. It clears on any other accepted beat.
- Mode latch: on an accepted beat with sof=1, mode_q ← mode, and that beat uses the new mode. On all other beats mode_q holds, so mode changes mid-frame are ignored.
- Per-lane function, where x is the signed input and y is the In_d_W+1-bit intermediate:
  - bypass: y = x.
  - ReLU: y = (x<0) ? 0 : x.
  - leaky: y = (x<0) ? (x >>> LEAK_SH) : x. This is an arithmetic shift, rounding toward −∞, so −1 maps to −1.
  - clip: y = (x<0) ? 0 : min(x, CLIP).
- Narrowing:
  - y > 2^(Out_d_W−1)−1 gives 2^(Out_d_W−1)−1.
  - y < −2^(Out_d_W−1) gives −2^(Out_d_W−1).
  - Otherwise, take the low Out_d_W bits.
  - A lane saturates only when narrowing clamps it. Clip-mode limiting by CLIP is not saturation.
- sat_cnt increments by 1 on each output handshake (out_valid & out_ready) whose beat had any lane saturated. It sticks at 0xFFFF (no wrap).
- Pipeline: two register stages.
  - S1 computes y and saturation flags and latches mode_q.
  - S2 narrows and holds Z, out_last, and the saturate flag.

## Timing
- Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv, combinationally.
  - S1 and S2 both load only when adv=1; when adv=0 every register holds.
- Stage valids:
  - S1 valid ← in_valid & in_ready.
  - out_valid (S2 valid) ← S1 valid, on adv.
- Latency: exactly 2 cycles from accept to out_valid when out_ready stays high. Throughput is 1 beat per cycle.
- Handshake rules:
  - Z and out_last are stable while out_valid=1 and out_ready=0.
  - in_ready never depends on in_valid.
- Reset (clr=0 at a rising edge) has the following effect:
  - out_valid=0, S1 valid=0, Z=0, out_last=0.
  - sat_cnt=0, mode_q=00, sof=1.
  - in_ready reads 1 during and after reset, since out_valid=0.
  - Reset mid-frame discards any in-flight beats, and the next accepted beat starts a new frame.
- Simultaneous events:
  - An accept with in_last=1 in the same cycle as a mode change: the beat uses mode_q and the new mode applies from the next accepted beat.
  - A saturating output handshake in the same cycle as clr=0: reset wins.

## Test plan
- ReLU, 18→16, single beat with lanes {−5, 0, 7, −131072, 32767, 32768, 131071, 1, −1} -> after 2 cycles, Z lanes {0, 0, 7, 0, 32767, 32767, 32767, 1, 0}, and sat_cnt=1 once the beat is accepted.
- Leaky (LEAK_SH=3), lanes {−16, −1, −9, 40, …} -> {−2, −1, −2, 40, …}. Bypass with −40000 -> −32768 (saturated).
- Clip (CLIP=1536), lanes {2000, 1536, 1535, −3} -> {1536, 1536, 1535, 0}, with sat_cnt unchanged.
- Mode per frame: frame A of 3 beats with mode=01, mode switched to 10 after beat 1 -> all 3 beats are ReLU. Frame B then uses leaky from its first beat. out_last is asserted only on A's beat 3.
- Backpressure: stream 8 beats, out_ready toggling 1,0,0,1,… -> no beat lost or duplicated, Z held stable while stalled, in_ready=0 exactly when out_valid=1 & out_ready=0.
- Reset mid-stream: assert clr=0 for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, sat_cnt=0, and the next beat's mode is sampled fresh. 65540 saturating beats with no reset -> sat_cnt=0xFFFF.

Source files
------------

// File: rtl/act_stream.sv
// act_stream: two-stage CNN activation unit (bypass / ReLU / leaky / clipped ReLU)
// with per-lane saturating narrowing, per-frame mode latching and a sticky saturation counter.
module act_stream #(
    parameter int          In_d_W  = 18,
    parameter int          Out_d_W = 16,
    parameter int          R       = 3,
    parameter int          C       = 3,
    parameter int          LEAK_SH = 3,
    parameter int unsigned CLIP    = 6 << 8
) (
    input  logic                       clk_i,
    input  logic                       clr_i,
    input  logic [1:0]                 mode_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       in_last_i,
    input  logic [In_d_W*R*C-1:0]      x_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       out_last_o,
    output logic [Out_d_W*R*C-1:0]     z_o,
    output logic [15:0]                sat_cnt_o
);

    localparam int N = R * C;

    localparam logic signed [In_d_W:0] OUT_MAX =
        {{(In_d_W - Out_d_W + 2){1'b0}}, {(Out_d_W - 1){1'b1}}};
    localparam logic signed [In_d_W:0] OUT_MIN =
        {{(In_d_W - Out_d_W + 2){1'b1}}, {(Out_d_W - 1){1'b0}}};
    localparam logic signed [In_d_W:0] CLIP_Y = {1'b0, CLIP[In_d_W-1:0]};

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_RELU   = 2'b01,
        MODE_LEAKY  = 2'b10,
        MODE_CLIP   = 2'b11
    } mode_e;

    logic               adv;
    logic               accept;
    mode_e              beat_mode;

    logic               sof_q, sof_d;
    mode_e              mode_q, mode_d;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_last_q, s1_last_d;
    logic [N-1:0]       s1_hi_q, s1_hi_d;
    logic [N-1:0]       s1_lo_q, s1_lo_d;
    logic [Out_d_W-1:0] s1_ylo_q [N];
    logic [Out_d_W-1:0] s1_ylo_d [N];

    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               sat_q, sat_d;
    logic [Out_d_W*N-1:0] z_q, z_d;
    logic [15:0]        sat_cnt_q, sat_cnt_d;

    // The first beat of a frame uses the live mode input; later beats reuse the latched one.
    always_comb begin
        adv         = ~out_valid_q | out_ready_i;
        accept      = in_valid_i & adv;
        beat_mode   = sof_q ? mode_e'(mode_i) : mode_q;

        sof_d       = sof_q;
        mode_d      = mode_q;
        if (accept) begin
            sof_d = in_last_i;
            if (sof_q) begin
                mode_d = mode_e'(mode_i);
            end
        end

        s1_valid_d  = accept;
        s1_last_d   = in_last_i;
        out_valid_d = s1_valid_q;
        out_last_d  = s1_last_q;
        sat_d       = |(s1_hi_q | s1_lo_q);

        sat_cnt_d   = sat_cnt_q;
        if (out_valid_q & out_ready_i & sat_q & (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic signed [In_d_W-1:0] x;
        logic signed [In_d_W:0]   xe;
        logic signed [In_d_W:0]   y;

        assign x  = x_i[In_d_W*k +: In_d_W];
        assign xe = {x[In_d_W-1], x};

        always_comb begin
            y = xe;
            case (beat_mode)
                MODE_BYPASS: y = xe;
                MODE_RELU:   y = x[In_d_W-1] ? '0 : xe;
                MODE_LEAKY:  y = x[In_d_W-1] ? (xe >>> LEAK_SH) : xe;
                MODE_CLIP:   y = x[In_d_W-1] ? '0 : ((xe > CLIP_Y) ? CLIP_Y : xe);
                default:     y = xe;
            endcase
        end

        // Clip limiting happens before these compares, so it never counts as saturation.
        assign s1_hi_d[k]  = (y > OUT_MAX);
        assign s1_lo_d[k]  = (y < OUT_MIN);
        assign s1_ylo_d[k] = y[Out_d_W-1:0];

        assign z_d[Out_d_W*k +: Out_d_W] =
            s1_hi_q[k] ? OUT_MAX[Out_d_W-1:0] :
            (s1_lo_q[k] ? OUT_MIN[Out_d_W-1:0] : s1_ylo_q[k]);
    end

    // A stalled output freezes the whole pipeline, so a single enable covers every register.
    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            sof_q       <= 1'b1;
            mode_q      <= MODE_BYPASS;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_hi_q     <= '0;
            s1_lo_q     <= '0;
            s1_ylo_q    <= '{default: '0};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
            z_q         <= '0;
            sat_cnt_q   <= '0;
        end else if (adv) begin
            sof_q       <= sof_d;
            mode_q      <= mode_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_hi_q     <= s1_hi_d;
            s1_lo_q     <= s1_lo_d;
            s1_ylo_q    <= s1_ylo_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
            z_q         <= z_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign in_ready_o  = adv;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign z_o         = z_q;
    assign sat_cnt_o   = sat_cnt_q;

endmodule
